// File: rtl/control_sequencer.sv
// Multi-cycle control sequencer: fetch/decode/execute FSM driving one-hot
// datapath strobes from the state register and the decoded instruction.
module control_sequencer (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        run,
  input  logic        mem_ready,
  input  logic [31:0] ir,
  output logic        pc_out,
  output logic        pc_in,
  output logic        inc_pc,
  output logic        mar_in,
  output logic        read,
  output logic        mdr_in,
  output logic        mdr_out,
  output logic        ir_in,
  output logic        y_in,
  output logic        z_in,
  output logic        z_low_out,
  output logic        z_high_out,
  output logic        hi_in,
  output logic        hi_out,
  output logic        lo_in,
  output logic        lo_out,
  output logic [15:0] gpr_in,
  output logic [15:0] gpr_out,
  output logic [3:0]  alu_op,
  output logic        busy,
  output logic        halted,
  output logic        illegal,
  output logic [3:0]  state,
  output logic [15:0] instr_count
);

  typedef enum logic [3:0] {
    IDLE = 4'd0, T0 = 4'd1, T1 = 4'd2, T2 = 4'd3, T3 = 4'd4,
    T4 = 4'd5, T5 = 4'd6, T6 = 4'd7, HALT = 4'd8
  } state_t;

  state_t cur_state, nxt_state;
  logic [4:0] opcode;
  logic [3:0] ra, rb, rc, dec_alu;
  logic op_binary, op_unary, op_muldiv, op_nop, op_halt, op_illegal;
  logic retire;
  logic unused_ir_bits;

  assign opcode = ir[31:27];
  assign ra = ir[26:23];
  assign rb = ir[22:19];
  assign rc = ir[18:15];
  assign unused_ir_bits = ^ir[14:0];

  always_comb begin
    dec_alu = 4'b0000;
    op_binary = 1'b0;
    op_unary = 1'b0;
    op_muldiv = 1'b0;
    op_nop = 1'b0;
    op_halt = 1'b0;
    op_illegal = 1'b0;
    case (opcode)
      5'b01001: begin dec_alu = 4'b0000; op_binary = 1'b1; end
      5'b01010: begin dec_alu = 4'b0001; op_binary = 1'b1; end
      5'b00011: begin dec_alu = 4'b0010; op_binary = 1'b1; end
      5'b00100: begin dec_alu = 4'b0011; op_binary = 1'b1; end
      5'b00101: begin dec_alu = 4'b0100; op_binary = 1'b1; end
      5'b00110: begin dec_alu = 4'b0101; op_binary = 1'b1; end
      5'b00111: begin dec_alu = 4'b0110; op_binary = 1'b1; end
      5'b01000: begin dec_alu = 4'b0111; op_binary = 1'b1; end
      5'b01111: begin dec_alu = 4'b1000; op_binary = 1'b1; op_muldiv = 1'b1; end
      5'b10000: begin dec_alu = 4'b1001; op_binary = 1'b1; op_muldiv = 1'b1; end
      5'b10001: begin dec_alu = 4'b1010; op_unary = 1'b1; end
      5'b10010: begin dec_alu = 4'b1011; op_unary = 1'b1; end
      5'b11010: op_nop = 1'b1;
      5'b11011: op_halt = 1'b1;
      default:  op_illegal = 1'b1;
    endcase
  end

  // run is only consulted in IDLE and on the retiring cycle of an instruction
  always_comb begin
    nxt_state = cur_state;
    retire = 1'b0;
    case (cur_state)
      IDLE: if (run) nxt_state = T0;
      T0:   nxt_state = T1;
      T1:   if (mem_ready) nxt_state = T2;
      T2:   nxt_state = T3;
      T3: begin
        if (op_binary) nxt_state = T4;
        else if (op_unary) nxt_state = T5;
        else if (op_halt) begin
          retire = 1'b1;
          nxt_state = HALT;
        end else begin
          retire = op_nop;
          nxt_state = run ? T0 : IDLE;
        end
      end
      T4:   nxt_state = T5;
      T5: begin
        if (op_muldiv) nxt_state = T6;
        else begin
          retire = 1'b1;
          nxt_state = run ? T0 : IDLE;
        end
      end
      T6: begin
        retire = 1'b1;
        nxt_state = run ? T0 : IDLE;
      end
      HALT: nxt_state = HALT;
      default: nxt_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cur_state <= IDLE;
      instr_count <= 16'h0000;
      illegal <= 1'b0;
    end else begin
      cur_state <= nxt_state;
      if (retire) instr_count <= instr_count + 16'h0001;
      if (cur_state == T3 && op_illegal) illegal <= 1'b1;
    end
  end

  always_comb begin
    pc_out = 1'b0;   pc_in = 1'b0;      inc_pc = 1'b0;    mar_in = 1'b0;
    read = 1'b0;     mdr_in = 1'b0;     mdr_out = 1'b0;   ir_in = 1'b0;
    y_in = 1'b0;     z_in = 1'b0;       z_low_out = 1'b0; z_high_out = 1'b0;
    hi_in = 1'b0;    hi_out = 1'b0;     lo_in = 1'b0;     lo_out = 1'b0;
    gpr_in = 16'h0000;
    gpr_out = 16'h0000;
    alu_op = 4'b0000;
    case (cur_state)
      T0: begin pc_out = 1'b1; mar_in = 1'b1; inc_pc = 1'b1; end
      T1: begin read = 1'b1; mdr_in = 1'b1; end
      T2: begin mdr_out = 1'b1; ir_in = 1'b1; end
      T3: begin
        alu_op = dec_alu;
        if (op_binary) begin
          gpr_out = 16'h0001 << rb;
          y_in = 1'b1;
        end else if (op_unary) begin
          gpr_out = 16'h0001 << rb;
          z_in = 1'b1;
        end
      end
      T4: begin
        alu_op = dec_alu;
        gpr_out = 16'h0001 << rc;
        z_in = 1'b1;
      end
      T5: begin
        alu_op = dec_alu;
        z_low_out = 1'b1;
        if (op_muldiv) lo_in = 1'b1;
        else gpr_in = 16'h0001 << ra;
      end
      T6: begin
        alu_op = dec_alu;
        z_high_out = 1'b1;
        hi_in = 1'b1;
      end
      default: ;
    endcase
  end

  assign state = cur_state;
  assign busy = (cur_state != IDLE) && (cur_state != HALT);
  assign halted = (cur_state == HALT);

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: stimulus queues per-cycle expected
// outputs, a negedge monitor pops and compares them and checks bus rules.
module tb_control_sequencer;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic run = 1'b0;
  logic mem_ready = 1'b0;
  logic [31:0] ir = 32'h0;
  logic pc_out, pc_in, inc_pc, mar_in, read, mdr_in, mdr_out, ir_in;
  logic y_in, z_in, z_low_out, z_high_out, hi_in, hi_out, lo_in, lo_out;
  logic [15:0] gpr_in, gpr_out, instr_count;
  logic [3:0] alu_op, state;
  logic busy, halted, illegal;

  localparam logic [15:0] C_PC_OUT = 16'h8000, C_INC_PC = 16'h2000, C_MAR_IN = 16'h1000;
  localparam logic [15:0] C_READ = 16'h0800, C_MDR_IN = 16'h0400, C_MDR_OUT = 16'h0200;
  localparam logic [15:0] C_IR_IN = 16'h0100, C_Y_IN = 16'h0080, C_Z_IN = 16'h0040;
  localparam logic [15:0] C_ZLO = 16'h0020, C_ZHI = 16'h0010, C_HI_IN = 16'h0008;
  localparam logic [15:0] C_LO_IN = 16'h0002;
  localparam logic [31:0] AND_5_2_4 = 32'h4A920000;
  localparam logic [31:0] MUL_5_2_4 = 32'h7A920000;

  typedef struct {
    string name;
    logic [3:0] st;
    logic [15:0] ctrl;
    logic [15:0] gin;
    logic [15:0] gout;
    logic [3:0] alu;
    logic ill;
    logic [15:0] cnt;
  } exp_t;

  exp_t expQ[$];
  int checks = 0;
  int errors = 0;

  control_sequencer dut (
    .clk(clk), .reset_n(reset_n), .run(run), .mem_ready(mem_ready), .ir(ir),
    .pc_out(pc_out), .pc_in(pc_in), .inc_pc(inc_pc), .mar_in(mar_in),
    .read(read), .mdr_in(mdr_in), .mdr_out(mdr_out), .ir_in(ir_in),
    .y_in(y_in), .z_in(z_in), .z_low_out(z_low_out), .z_high_out(z_high_out),
    .hi_in(hi_in), .hi_out(hi_out), .lo_in(lo_in), .lo_out(lo_out),
    .gpr_in(gpr_in), .gpr_out(gpr_out), .alu_op(alu_op),
    .busy(busy), .halted(halted), .illegal(illegal), .state(state),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mkIr(input logic [4:0] op, input logic [3:0] a,
                                       input logic [3:0] b, input logic [3:0] c);
    return {op, a, b, c, 15'b0};
  endfunction

  function automatic logic [15:0] ctrlVec();
    return {pc_out, pc_in, inc_pc, mar_in, read, mdr_in, mdr_out, ir_in,
            y_in, z_in, z_low_out, z_high_out, hi_in, hi_out, lo_in, lo_out};
  endfunction

  task automatic checkOutput(input exp_t e);
    logic [15:0] c;
    logic eb, eh;
    c = ctrlVec();
    eb = (e.st != 4'd0) && (e.st != 4'd8);
    eh = (e.st == 4'd8);
    checks++;
    if (state !== e.st || c !== e.ctrl || gpr_in !== e.gin || gpr_out !== e.gout ||
        alu_op !== e.alu || illegal !== e.ill || instr_count !== e.cnt ||
        busy !== eb || halted !== eh) begin
      errors++;
      $display("[TB] FAIL %s: got st=%0d ctrl=%h gin=%h gout=%h alu=%h ill=%b cnt=%h busy=%b halted=%b; want st=%0d ctrl=%h gin=%h gout=%h alu=%h ill=%b cnt=%h busy=%b halted=%b",
               e.name, state, c, gpr_in, gpr_out, alu_op, illegal, instr_count, busy, halted,
               e.st, e.ctrl, e.gin, e.gout, e.alu, e.ill, e.cnt, eb, eh);
    end
  endtask

  task automatic pushExp(input string n, input logic [3:0] st, input logic [15:0] c,
                         input logic [15:0] gi, input logic [15:0] go, input logic [3:0] a,
                         input logic il, input logic [15:0] cnt);
    exp_t e;
    e.name = n; e.st = st; e.ctrl = c; e.gin = gi; e.gout = go;
    e.alu = a; e.ill = il; e.cnt = cnt;
    expQ.push_back(e);
  endtask

  task automatic pushFetch(input string tag, input int nT1, input logic il, input logic [15:0] cnt);
    pushExp({tag, "_t0"}, 4'd1, C_PC_OUT | C_MAR_IN | C_INC_PC, 16'h0, 16'h0, 4'h0, il, cnt);
    for (int i = 0; i < nT1; i++)
      pushExp({tag, "_t1"}, 4'd2, C_READ | C_MDR_IN, 16'h0, 16'h0, 4'h0, il, cnt);
    pushExp({tag, "_t2"}, 4'd3, C_MDR_OUT | C_IR_IN, 16'h0, 16'h0, 4'h0, il, cnt);
  endtask

  task automatic applyStimulus(input logic [31:0] instr, input logic runv, input logic mr);
    ir = instr;
    run = runv;
    mem_ready = mr;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic waitDrain(input string tag);
    int n;
    n = 0;
    while (expQ.size() > 0 && n < 100) begin
      step();
      n++;
    end
    if (expQ.size() > 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s_drain: %0d expected entries left, want 0", tag, expQ.size());
      expQ.delete();
    end
  endtask

  // Monitor: bus exclusivity / one-hot every cycle, plus scoreboard pop
  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      int drivers;
      drivers = pc_out + mdr_out + z_low_out + z_high_out + hi_out + lo_out + $countones(gpr_out);
      checks++;
      if (drivers > 1 || !$onehot0(gpr_in) || !$onehot0(gpr_out)) begin
        errors++;
        $display("[TB] FAIL bus_excl: drivers=%0d gin=%h gout=%h, want drivers<=1 and one-hot-or-zero strobes",
                 drivers, gpr_in, gpr_out);
      end
      if (expQ.size() > 0) checkOutput(expQ.pop_front());
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation still running, want completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    exp_t e0;
    e0.name = "reset_init"; e0.st = 4'd0; e0.ctrl = 16'h0; e0.gin = 16'h0;
    e0.gout = 16'h0; e0.alu = 4'h0; e0.ill = 1'b0; e0.cnt = 16'h0;
    #1 reset_n = 1'b0;
    #1 checkOutput(e0);
    #10 reset_n = 1'b1;
    step();

    $display("[TB] and R5,R2,R4");
    applyStimulus(AND_5_2_4, 1'b1, 1'b1);
    pushExp("s1_idle", 4'd0, 16'h0, 16'h0, 16'h0, 4'h0, 1'b0, 16'd0);
    pushFetch("s1", 1, 1'b0, 16'd0);
    pushExp("s1_t3", 4'd4, C_Y_IN, 16'h0, 16'h0004, 4'h0, 1'b0, 16'd0);
    pushExp("s1_t4", 4'd5, C_Z_IN, 16'h0, 16'h0010, 4'h0, 1'b0, 16'd0);
    pushExp("s1_t5", 4'd6, C_ZLO, 16'h0020, 16'h0, 4'h0, 1'b0, 16'd0);
    pushExp("s1_end", 4'd0, 16'h0, 16'h0, 16'h0, 4'h0, 1'b0, 16'd1);
    step();
    run = 1'b0;
    waitDrain("s1");

    $display("[TB] add R3,R3,R3 with memory wait states");
    applyStimulus(mkIr(5'b00011, 4'd3, 4'd3, 4'd3), 1'b1, 1'b0);
    pushExp("s2_idle", 4'd0, 16'h0, 16'h0, 16'h0, 4'h0, 1'b0, 16'd1);
    pushFetch("s2", 4, 1'b0, 16'd1);
    pushExp("s2_t3", 4'd4, C_Y_IN, 16'h0, 16'h0008, 4'h2, 1'b0, 16'd1);
    pushExp("s2_t4", 4'd5, C_Z_IN, 16'h0, 16'h0008, 4'h2, 1'b0, 16'd1);
    pushExp("s2_t5", 4'd6, C_ZLO, 16'h0008, 16'h0, 4'h2, 1'b0, 16'd1);
    pushExp("s2_end", 4'd0, 16'h0, 16'h0, 16'h0, 4'h0, 1'b0, 16'd2);
    step();
    run = 1'b0;
    repeat (4) step();
    mem_ready = 1'b1;
    waitDrain("s2");

    $display("[TB] mul R5,R2,R4");
    applyStimulus(MUL_5_2_4, 1'b1, 1'b1);
    pushExp("s3_idle", 4'd0, 16'h0, 16'h0, 16'h0, 4'h0, 1'b0, 16'd2);
    pushFetch("s3", 1, 1'b0, 16'd2);
    pushExp("s3_t3", 4'd4, C_Y_IN, 16'h0, 16'h0004, 4'h8, 1'b0, 16'd2);
    pushExp("s3_t4", 4'd5, C_Z_IN, 16'h0, 16'h0010, 4'h8, 1'b0, 16'd2);
    pushExp("s3_t5", 4'd6, C_ZLO | C_LO_IN, 16'h0, 16'h0, 4'h8, 1'b0, 16'd2);
    pushExp("s3_t6", 4'd7, C_ZHI | C_HI_IN, 16'h0, 16'h0, 4'h8, 1'b0, 16'd2);
    pushExp("s3_end", 4'd0, 16'h0, 16'h0, 16'h0, 4'h0, 1'b0, 16'd3);
    step();
    run = 1'b0;
    waitDrain("s3");

    $display("[TB] neg R1,R6");
    applyStimulus(mkIr(5'b10001, 4'd1, 4'd6, 4'd0), 1'b1, 1'b1);
    pushExp("s4_idle", 4'd0, 16'h0, 16'h0, 16'h0, 4'h0, 1'b0, 16'd3);
    pushFetch("s4", 1, 1'b0, 16'd3);
    pushExp("s4_t3", 4'd4, C_Z_IN, 16'h0, 16'h0040, 4'hA, 1'b0, 16'd3);
    pushExp("s4_t5", 4'd6, C_ZLO, 16'h0002, 16'h0, 4'hA, 1'b0, 16'd3);
    pushExp("s4_end", 4'd0, 16'h0, 16'h0, 16'h0, 4'h0, 1'b0, 16'd4);
    step();
    run = 1'b0;
    waitDrain("s4");

    $display("[TB] nop");
    applyStimulus(mkIr(5'b11010, 4'd0, 4'd0, 4'd0), 1'b1, 1'b1);
    pushExp("s5_idle", 4'd0, 16'h0, 16'h0, 16'h0, 4'h0, 1'b0, 16'd4);
    pushFetch("s5", 1, 1'b0, 16'd4);
    pushExp("s5_t3", 4'd4, 16'h0, 16'h0, 16'h0, 4'h0, 1'b0, 16'd4);
    pushExp("s5_end", 4'd0, 16'h0, 16'h0, 16'h0, 4'h0, 1'b0, 16'd5);
    step();
    run = 1'b0;
    waitDrain("s5");

    $display("[TB] illegal opcode, back-to-back fetch, reset in T4");
    applyStimulus(32'hF8000000, 1'b1, 1'b1);
    pushExp("s6_idle", 4'd0, 16'h0, 16'h0, 16'h0, 4'h0, 1'b0, 16'd5);
    pushFetch("s6a", 1, 1'b0, 16'd5);
    pushExp("s6_t3ill", 4'd4, 16'h0, 16'h0, 16'h0, 4'h0, 1'b0, 16'd5);
    pushFetch("s6b", 1, 1'b1, 16'd5);
    pushExp("s6_t3", 4'd4, C_Y_IN, 16'h0, 16'h0004, 4'h0, 1'b1, 16'd5);
    pushExp("s6_t4", 4'd5, C_Z_IN, 16'h0, 16'h0010, 4'h0, 1'b1, 16'd5);
    repeat (5) step();
    ir = AND_5_2_4;
    run = 1'b0;
    repeat (4) step();
    @(negedge clk);
    #1 reset_n = 1'b0;
    e0.name = "s6_async_reset";
    #1 checkOutput(e0);
    @(posedge clk);
    #2 e0.name = "s6_reset_held";
    checkOutput(e0);
    reset_n = 1'b1;
    step();
    pushExp("s6_after_reset", 4'd0, 16'h0, 16'h0, 16'h0, 4'h0, 1'b0, 16'd0);
    pushExp("s6_after_reset2", 4'd0, 16'h0, 16'h0, 16'h0, 4'h0, 1'b0, 16'd0);
    waitDrain("s6");

    $display("[TB] halt");
    applyStimulus(32'hD8000000, 1'b1, 1'b1);
    pushExp("s7_idle", 4'd0, 16'h0, 16'h0, 16'h0, 4'h0, 1'b0, 16'd0);
    pushFetch("s7", 1, 1'b0, 16'd0);
    pushExp("s7_t3", 4'd4, 16'h0, 16'h0, 16'h0, 4'h0, 1'b0, 16'd0);
    for (int i = 0; i < 5; i++)
      pushExp("s7_halt", 4'd8, 16'h0, 16'h0, 16'h0, 4'h0, 1'b0, 16'd1);
    repeat (5) step();
    for (int i = 0; i < 4; i++) begin
      step();
      run = ~run;
    end
    waitDrain("s7");
    reset_n = 1'b0;
    e0.name = "s7_reset";
    #1 checkOutput(e0);
    #3 reset_n = 1'b1;
    run = 1'b0;
    step();
    pushExp("s7_after_reset", 4'd0, 16'h0, 16'h0, 16'h0, 4'h0, 1'b0, 16'd0);
    waitDrain("s7r");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk input 1 (rising-edge clock); reset_n input 1 (asynchronous, active-low reset).
REQ-002 The block SHALL have these inputs: run 1 (level; permits fetch of next instruction); mem_ready 1 (memory read data valid on m_data_in this cycle); ir 32 (instruction register contents from datapath).
REQ-003 The block SHALL have these datapath control outputs: pc_out, pc_in, inc_pc, mar_in, read, mdr_in, mdr_out, ir_in, y_in, z_in, z_low_out, z_high_out, hi_in, hi_out, lo_in, lo_out (1 bit each); gpr_in 16 and gpr_out 16 (one-hot register strobes); alu_op 4.
REQ-004 The block SHALL have these status outputs: busy 1 (state not IDLE/HALT); halted 1; illegal 1 (sticky); state 4 (debug state code); instr_count 16 (retired instructions).

Function
REQ-005 Decode SHALL be as follows: opcode=ir[31:27], ra=ir[26:23], rb=ir[22:19], rc=ir[18:15].
REQ-006 Opcode to alu_op mapping SHALL be: and 01001->0000, or 01010->0001, add 00011->0010, sub 00100->0011, shr 00101->0100, shl 00110->0101, ror 00111->0110, rol 01000->0111, mul 01111->1000, div 10000->1001, neg 10001->1010, not 10010->1011; nop 11010, halt 11011; all other opcodes are illegal.
REQ-007 The FSM SHALL have states IDLE=0, T0=1, T1=2, T2=3, T3=4, T4=5, T5=6, T6=7, HALT=8; the state output SHALL equal the state code.
REQ-008 Control outputs SHALL be a Moore decode of the state register, held for the whole cycle, and 0 in all states or cycles not listed.
REQ-009 IDLE: all controls 0; go to T0 when run=1, otherwise stay.
REQ-010 T0: pc_out, mar_in, inc_pc; go to T1.
REQ-011 T1: read, mdr_in; stay while mem_ready=0; go to T2 on the cycle mem_ready=1 is sampled (minimum 1 cycle).
REQ-012 T2: mdr_out, ir_in; go to T3 (ir is valid from T3 onward).
REQ-013 T3 binary ALU ops (and..rol, mul, div): gpr_out[rb], y_in; go to T4.
REQ-014 T3 unary ops (neg, not): gpr_out[rb], z_in, alu_op driven; go to T5.
REQ-015 T3 nop: no controls; instr_count+1; go to IDLE if run=0, else T0.
REQ-016 T3 halt: no controls; instr_count+1; go to HALT.
REQ-017 T3 illegal opcode: no controls; set illegal; instr_count unchanged; go to IDLE if run=0, else T0.
REQ-018 T4: gpr_out[rc], z_in, alu_op driven; go to T5.
REQ-019 T5 for non-mul/div ops: z_low_out, gpr_in[ra]; instr_count+1; go to IDLE if run=0, else T0.
REQ-020 T5 for mul/div: z_low_out, lo_in; go to T6.
REQ-021 T6: z_high_out, hi_in; instr_count+1; go to IDLE if run=0, else T0.
REQ-022 HALT: all controls 0; halted=1; run ignored; exit only by reset.
REQ-023 alu_op SHALL hold the decoded value from T3 through T6 and be 0000 otherwise.
REQ-024 Bus exclusivity: at most one of pc_out, mdr_out, z_low_out, z_high_out, hi_out, lo_out, or any gpr_out bit SHALL be 1 in any cycle.
REQ-025 gpr_in and gpr_out SHALL each be zero or one-hot; ra=rb=rc is legal (for example, and R3,R3,R3).
REQ-026 instr_count SHALL wrap 0xFFFF->0x0000.
REQ-027 run deasserted mid-instruction SHALL NOT abort it; it is sampled only at the instruction end and in IDLE.
REQ-028 hi_out, lo_out and pc_in SHALL be held 0 (reserved for later opcodes).

Reset
REQ-029 reset_n=0 SHALL immediately force state=IDLE, all control outputs 0, alu_op=0, illegal=0, halted=0, instr_count=0, independent of clk.
REQ-030 Reset asserted mid-instruction (including a T1 wait) SHALL abandon the instruction with no partial register write.
REQ-031 After reset_n rises, the first T0 SHALL occur on the first rising clk edge with run=1.

Verification
REQ-032 Scenario: run=1, mem_ready=1, ir=0x4A920000 (and R5,R2,R4) -> T0,T1,T2,T3(gpr_out=0x0004,y_in),T4(gpr_out=0x0010,z_in,alu_op=0000),T5(z_low_out,gpr_in=0x0020); instr_count=1.
REQ-033 Scenario: mem_ready held 0 for 3 cycles in T1 -> read=mdr_in=1 for 4 cycles, then T2.
REQ-034 Scenario: ir=0x7A920000 (mul R5,R2,R4) -> T5 has lo_in=1, T6 has hi_in=1 and z_high_out=1, gpr_in=0 throughout.
REQ-035 Scenario: ir=0xD8000000 (halt) -> HALT after T3, halted=1, run toggling has no effect, reset returns to IDLE.
REQ-036 Scenario: ir=0xF8000000 (illegal) -> illegal=1 sticky, instr_count unchanged, next fetch starts; reset_n pulsed low in T4 -> all outputs 0 asynchronously, no gpr_in pulse.
REQ-037 Every scenario SHALL check the bus-exclusivity and one-hot properties each cycle.
